// File: rtl/uart_rx_core.sv
// UART serial receive engine: synchronizes the line, validates start bits, samples
// each bit at mid-period and hands completed words out over a valid/ready handshake.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 framing_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic          ODD_SEL   = (PARITY_ODD != 0);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic                 syncA_q, syncA_d;
    logic                 rsSync_q, rsSync_d;
    logic                 rsPrev_q, rsPrev_d;
    logic [1:0]           fill_q, fill_d;
    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bitIdx_q, bitIdx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parFail_q, parFail_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 oerr_q, oerr_d;

    logic accept;
    logic cntZero;

    assign accept  = valid_q && rx_ready;
    assign cntZero = (cnt_q == '0);

    always_comb begin
        syncA_d   = uart_rx;
        rsSync_d  = syncA_q;
        rsPrev_d  = rsSync_q;
        // Edge detection is held off until the delayed flop carries a real line sample,
        // so a line already low when reset releases is never taken as a start.
        fill_d    = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        parFail_d = parFail_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        oerr_d    = 1'b0;

        if (accept) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (fill_q == 2'd3 && rsPrev_q && !rsSync_q) begin
                    state_d   = START;
                    cnt_d     = HALF_LOAD;
                    parFail_d = 1'b0;
                end
            end
            START: begin
                if (!cntZero) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rsSync_q) begin
                    state_d = IDLE;
                end else begin
                    state_d  = DATA;
                    cnt_d    = FULL_LOAD;
                    bitIdx_d = 3'd0;
                end
            end
            DATA: begin
                if (!cntZero) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d = {rsSync_q, shift_q[DATA_BITS-1:1]};
                    cnt_d   = FULL_LOAD;
                    if (bitIdx_q == LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (!cntZero) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    parFail_d = (rsSync_q != ((^shift_q) ^ ODD_SEL));
                    state_d   = STOP;
                    cnt_d     = FULL_LOAD;
                end
            end
            STOP: begin
                if (!cntZero) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // A bad stop bit outranks parity; only clean frames reach the handshake.
                    state_d = IDLE;
                    if (!rsSync_q) begin
                        ferr_d = 1'b1;
                    end else if (parFail_q) begin
                        perr_d = 1'b1;
                    end else if (!valid_q || accept) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        oerr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            syncA_q   <= 1'b1;
            rsSync_q  <= 1'b1;
            rsPrev_q  <= 1'b1;
            fill_q    <= 2'd0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bitIdx_q  <= 3'd0;
            shift_q   <= '0;
            parFail_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            oerr_q    <= 1'b0;
        end else begin
            syncA_q   <= syncA_d;
            rsSync_q  <= rsSync_d;
            rsPrev_q  <= rsPrev_d;
            fill_q    <= fill_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            parFail_q <= parFail_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            oerr_q    <= oerr_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign framing_err = ferr_q;
    assign parity_err  = perr_q;
    assign overrun_err = oerr_q;
    assign busy        = (state_q != IDLE);

endmodule
